// File: rtl/mult_seq_64.sv
// Iterative shift-add multiplier for MULT/MULTU. One shift-add step per cycle,
// then a final two's-complement fix-up pass through the same 64-bit adder.

module cla_adder_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        ci,
    output logic [63:0] s
);
    logic [62:0] g;
    logic [63:0] p;
    logic [63:0] c;
    logic [14:0] gg;
    logic [14:0] gp;
    logic [15:0] gc;

    assign g = a[62:0] & b[62:0];
    assign p = a ^ b;

    // 4-bit lookahead groups; group carries chain through the group generate/propagate terms
    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < 15; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = ci;
        for (int k = 0; k < 15; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 16; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
    end

    assign s = p ^ c;
endmodule

module mult_seq_64 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t          state;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic            neg;

    logic [PW-1:0]   add_a;
    logic [PW-1:0]   add_b;
    logic            add_ci;
    logic [PW-1:0]   add_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic sgn);
        return (sgn && x[WIDTH-1]) ? WIDTH'(~x + WIDTH'(1)) : x;
    endfunction

    // Adder input mux: accumulate in CALC, conditional negate in SIGN
    always_comb begin
        add_a  = acc;
        add_b  = mplier[0] ? mcand : '0;
        add_ci = 1'b0;
        if (state == SIGN) begin
            add_a  = neg ? ~acc : acc;
            add_b  = '0;
            add_ci = neg;
        end
    end

    cla_adder_64 u_adder_64bits (
        .a  (add_a),
        .b  (add_b),
        .ci (add_ci),
        .s  (add_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, magnitude(a, is_signed)};
                        mplier <= magnitude(b, is_signed);
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= add_s;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    product <= add_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_64.sv
// Scoreboard bench for mult_seq_64: directed operands, expected products queued at issue
// and compared by an independent done monitor along with latency and busy length.

module tb_mult_seq_64;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    mult_seq_64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_q[$];
    int          due_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          exp_dones = 0;
    int          busy_len = 0;
    logic [63:0] mon_e;
    int          mon_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_len = 0;
        end else begin
            if (busy) busy_len++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_done: got done=1 product %h, expected no pulse", product);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_d = due_q.pop_front();
                    check("product", product, mon_e);
                    check("latency_cycle", 64'(cyc), 64'(mon_d));
                    check("busy_cycles", 64'(busy_len), 64'd33);
                end
                busy_len = 0;
            end
        end
    end

    task automatic issue(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e, input bit sync_neg);
        if (sync_neg) @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        a         = x;
        b         = y;
        @(posedge clk);
        #1;
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom);
        exp_q.push_back(e);
        due_q.push_back(cyc + 33);
        exp_dones++;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done within 100 cycles, expected a pulse");
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        issue(1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A, 1'b1);                 wait_done();
        issue(1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);         wait_done();
        issue(1'b0, 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, 1'b1);         wait_done();
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1); wait_done();
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1); wait_done();
        issue(1'b0, 32'd0, 32'h1234_5678, 64'd0, 1'b1);                           wait_done();
        issue(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b1); wait_done();

        // start while busy must be ignored
        issue(1'b1, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);

        // reset mid-operation aborts it
        issue(1'b0, 32'd100, 32'd100, 64'd10000, 1'b1);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        exp_dones--;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_product", product, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        issue(1'b0, 32'd3, 32'd4, 64'd12, 1'b0);
        wait_done();

        // back-to-back: start issued in the done cycle
        issue(1'b0, 32'd5, 32'd7, 64'd35, 1'b1);
        wait_done();
        issue(1'b0, 32'd2, 32'd3, 64'd6, 1'b0);
        repeat (10) @(negedge clk);
        check("product_held", product, 64'd35);
        wait_done();
        repeat (5) @(negedge clk);

        check("pending_results", 64'(exp_q.size()), 64'd0);
        check("done_pulses", 64'(done_cnt), 64'(exp_dones));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
